// File: rtl/mfp_reset_pkg.sv
`default_nettype none
// ============================================================================
// mfp_reset_pkg : shared state encoding and reset-cause codes for the sequencer
// Revision 1.0
// ============================================================================
package mfp_reset_pkg;

  typedef enum logic [1:0] {
    PERIPH_HOLD = 2'd0,
    CORE_HOLD   = 2'd1,
    RUN         = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_POR   = 2'b00;
  localparam logic [1:0] CAUSE_KEY   = 2'b01;
  localparam logic [1:0] CAUSE_EJTAG = 2'b10;

endpackage
`default_nettype wire

// File: rtl/mfp_sync_debounce.sv
`default_nettype none
// ============================================================================
// mfp_sync_debounce : preset-high synchroniser with optional debounce filter
// Revision 1.0
// ============================================================================
module mfp_sync_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_synced;

  // Preset to 1 so every input reads as released while resetn is low.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
    end
  end

  assign w_synced = r_sync[SYNC_STAGES-1];

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign dout = w_synced;
    end else begin : g_debounce
      localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

      logic [CNT_W-1:0] r_cnt;
      logic             r_state;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_cnt   <= '0;
          r_state <= 1'b1;
        end else if (w_synced == r_state) begin
          r_cnt <= '0;
        end else if (r_cnt == CNT_LAST) begin
          r_cnt   <= '0;
          r_state <= w_synced;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign dout = r_state;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mfp_reset_sequencer.sv
`default_nettype none
// ============================================================================
// mfp_reset_sequencer : merges PLL lock, reset key and EJTAG into sequenced resets
// Revision 1.0
// ============================================================================
module mfp_reset_sequencer
  import mfp_reset_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int PERIPH_CYCLES   = 16,
  parameter int CORE_CYCLES     = 64
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_n,
  input  logic       ej_rst_n,
  output logic       sys_reset,
  output logic       cold_reset,
  output logic       periph_resetn,
  output logic [1:0] reset_cause,
  output logic       busy
);

  localparam int CNT_MAX = (PERIPH_CYCLES > CORE_CYCLES) ? PERIPH_CYCLES : CORE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] PERIPH_LAST = CNT_W'(PERIPH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(CORE_CYCLES - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_key_prev;
  logic             w_key_deb;
  logic             w_ej_sync;
  logic             w_key_press;
  logic             w_key_low;
  logic             w_ej_low;

  mfp_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_db (
    .clk   (clk),
    .resetn(resetn),
    .din   (key_n),
    .dout  (w_key_deb)
  );

  mfp_sync_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(0)
  ) u_ej_sync (
    .clk   (clk),
    .resetn(resetn),
    .din   (ej_rst_n),
    .dout  (w_ej_sync)
  );

  assign w_key_low   = ~w_key_deb;
  assign w_ej_low    = ~w_ej_sync;
  assign w_key_press = r_key_prev & ~w_key_deb;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_key_prev <= 1'b1;
    end else begin
      r_key_prev <= w_key_deb;
    end
  end

  // PERIPH_HOLD counts up from the reset value of 0; CORE_HOLD counts down to 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= PERIPH_HOLD;
      r_cnt         <= '0;
      sys_reset     <= 1'b1;
      cold_reset    <= 1'b1;
      periph_resetn <= 1'b0;
      busy          <= 1'b1;
      reset_cause   <= CAUSE_POR;
    end else begin
      case (r_state)
        PERIPH_HOLD: begin
          if (r_cnt == PERIPH_LAST) begin
            r_state       <= CORE_HOLD;
            r_cnt         <= CORE_LAST;
            periph_resetn <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        CORE_HOLD: begin
          if (w_ej_low) begin
            reset_cause <= CAUSE_EJTAG;
            cold_reset  <= 1'b1;
            r_cnt       <= CORE_LAST;
          end else if (w_key_low) begin
            // Key presses only extend the hold; cause and cold flag are kept.
            r_cnt <= CORE_LAST;
          end else if (r_cnt == '0) begin
            r_state    <= RUN;
            sys_reset  <= 1'b0;
            cold_reset <= 1'b0;
            busy       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        RUN: begin
          if (w_ej_low) begin
            r_state     <= CORE_HOLD;
            r_cnt       <= CORE_LAST;
            sys_reset   <= 1'b1;
            cold_reset  <= 1'b1;
            busy        <= 1'b1;
            reset_cause <= CAUSE_EJTAG;
          end else if (w_key_press) begin
            r_state     <= CORE_HOLD;
            r_cnt       <= CORE_LAST;
            sys_reset   <= 1'b1;
            cold_reset  <= 1'b0;
            busy        <= 1'b1;
            reset_cause <= CAUSE_KEY;
          end
        end
        default: begin
          r_state <= PERIPH_HOLD;
          r_cnt   <= '0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mfp_reset_sequencer.sv
`default_nettype none
// ============================================================================
// tb_mfp_reset_sequencer : randomized self-checking bench against a timeline model
// Revision 1.0
// ============================================================================
module tb_mfp_reset_sequencer;

  localparam int S     = 2;
  localparam int D     = 8;
  localparam int P     = 4;
  localparam int C     = 6;
  localparam int NEVER = 1000000;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       key_n = 1'b1;
  logic       ej_rst_n = 1'b1;
  logic       sys_reset;
  logic       cold_reset;
  logic       periph_resetn;
  logic [1:0] reset_cause;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] cause_model = 2'b00;

  always #5 clk = ~clk;

  mfp_reset_sequencer #(
    .SYNC_STAGES    (S),
    .DEBOUNCE_CYCLES(D),
    .PERIPH_CYCLES  (P),
    .CORE_CYCLES    (C)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .key_n        (key_n),
    .ej_rst_n     (ej_rst_n),
    .sys_reset    (sys_reset),
    .cold_reset   (cold_reset),
    .periph_resetn(periph_resetn),
    .reset_cause  (reset_cause),
    .busy         (busy)
  );

  // Output vector order: {sys_reset, cold_reset, periph_resetn, busy, reset_cause}
  task automatic test_reset();
    logic [5:0] got;
    resetn = 1'b0;
    @(posedge clk); #1;
    got = {sys_reset, cold_reset, periph_resetn, busy, reset_cause};
    checks++;
    if (got !== 6'b110100) begin
      errors++;
      $display("FAIL reset_state got=%b exp=%b", got, 6'b110100);
    end
  endtask

  // Release at edge 0: periph at P, core and cold at P+C.
  task automatic test_power_on(input int low_cycles);
    logic [5:0] got, exp;
    resetn   = 1'b0;
    key_n    = 1'b1;
    ej_rst_n = 1'b1;
    repeat (low_cycles) @(posedge clk);
    #1;
    resetn      = 1'b1;
    cause_model = 2'b00;
    for (int t = 1; t <= P + C + 3; t++) begin
      @(posedge clk); #1;
      exp = {t < P + C, t < P + C, t >= P, t < P + C, cause_model};
      got = {sys_reset, cold_reset, periph_resetn, busy, reset_cause};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL power_on t=%0d got=%b exp=%b", t, got, exp);
      end
    end
  endtask

  // Key held lk cycles from edge 0; EJTAG low le cycles from edge o.
  // Timeline: debounced key falls at S+D, EJTAG seen at o+S+1; hold ends C
  // cycles after the later of the debounced/synchronised releases.
  task automatic test_trigger(input string name, input bit key_on, input int lk,
                              input bit ej_on, input int o, input int le);
    int key_rise, ej_rise, rise, rel, fall, last;
    logic sys_e, cold_e;
    logic [5:0] got, exp;
    key_rise = (key_on && lk >= D) ? S + D + 1 : NEVER;
    ej_rise  = ej_on ? o + S + 1 : NEVER;
    rise     = (key_rise < ej_rise) ? key_rise : ej_rise;
    rel = 0;
    if (key_rise != NEVER) rel = lk + S + D;
    if (ej_on && (o + le + S > rel)) rel = o + le + S;
    fall = (rise != NEVER) ? rel + C : 0;
    last = fall;
    if (key_on && (lk + S + D > last)) last = lk + S + D;
    if (ej_on && (o + le + S > last)) last = o + le + S;
    last = last + 3;
    @(posedge clk); #1;
    key_n    = !(key_on && lk > 0);
    ej_rst_n = !(ej_on && o == 0 && le > 0);
    for (int t = 1; t <= last; t++) begin
      @(posedge clk); #1;
      if (t == rise) cause_model = (ej_rise <= t) ? 2'b10 : 2'b01;
      if (t == ej_rise) cause_model = 2'b10;
      sys_e  = (t >= rise) && (t < fall);
      cold_e = sys_e && (t >= ej_rise);
      exp = {sys_e, cold_e, 1'b1, sys_e, cause_model};
      got = {sys_reset, cold_reset, periph_resetn, busy, reset_cause};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s t=%0d lk=%0d o=%0d le=%0d got=%b exp=%b",
                 name, t, lk, o, le, got, exp);
      end
      key_n    = !(key_on && t < lk);
      ej_rst_n = !(ej_on && t >= o && t < o + le);
    end
  endtask

  task automatic test_key_glitch();
    test_trigger("key_glitch", 1'b1, int'($urandom_range(1, D - 1)), 1'b0, 0, 0);
  endtask

  task automatic test_key_press();
    test_trigger("key_press", 1'b1, int'($urandom_range(D, 30)), 1'b0, 0, 0);
  endtask

  task automatic test_ejtag();
    test_trigger("ejtag", 1'b0, 0, 1'b1, 0, int'($urandom_range(1, 6)));
  endtask

  task automatic test_simultaneous();
    test_trigger("simultaneous", 1'b1, int'($urandom_range(D + 2, 25)),
                 1'b1, S + D - S, int'($urandom_range(1, 10)));
  endtask

  task automatic test_upgrade();
    test_trigger("upgrade", 1'b1, int'($urandom_range(20, 30)),
                 1'b1, int'($urandom_range(10, 15)), int'($urandom_range(1, 15)));
  endtask

  task automatic test_async_abort();
    logic [5:0] got;
    @(posedge clk); #1;
    ej_rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    got = {sys_reset, cold_reset, periph_resetn, busy, reset_cause};
    checks++;
    if (got !== 6'b111110) begin
      errors++;
      $display("FAIL abort_pre_hold got=%b exp=%b", got, 6'b111110);
    end
    #3;
    resetn = 1'b0;
    #1;
    got = {sys_reset, cold_reset, periph_resetn, busy, reset_cause};
    checks++;
    if (got !== 6'b110100) begin
      errors++;
      $display("FAIL abort_async got=%b exp=%b", got, 6'b110100);
    end
    ej_rst_n = 1'b1;
    test_power_on(int'($urandom_range(2, 5)));
  endtask

  initial begin
    test_reset();
    test_power_on(int'($urandom_range(2, 5)));
    for (int i = 0; i < 3; i++) test_key_glitch();
    for (int i = 0; i < 3; i++) test_key_press();
    for (int i = 0; i < 3; i++) test_ejtag();
    test_key_glitch();
    for (int i = 0; i < 2; i++) test_simultaneous();
    for (int i = 0; i < 3; i++) test_upgrade();
    test_key_press();
    test_async_abort();
    test_ejtag();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
